jpeg_byte_stuffer: RTL

JPEG_BYTE_STUFFER -- requirements
Module: jpeg_byte_stuffer

---
 rtl/jpeg_byte_stuffer_pkg.sv | 33 +++
 rtl/jpeg_byte_stuffer_word_fifo.sv | 46 ++++
 rtl/jpeg_byte_stuffer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/jpeg_byte_stuffer_pkg.sv
// Shared types and constants for the JPEG byte stuffer: FSM states,
// marker/stuff byte values, FIFO entry layout and a byte-lane selector.
package jpeg_byte_stuffer_pkg;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_EMIT   = 3'd1,
        ST_STUFF  = 3'd2,
        ST_EOI_FF = 3'd3,
        ST_EOI_D9 = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [7:0] EOI_HI = 8'hFF;
    localparam logic [7:0] EOI_LO = 8'hD9;
    localparam logic [7:0] STUFF  = 8'h00;

    // Entry layout: {last, bytes[2:0], data[31:0]}
    localparam int ENTRY_W = 36;

    // Pick byte lane idx of a word; lane 0 is first in stream order.
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/jpeg_byte_stuffer_word_fifo.sv
// Synchronous first-word-fall-through FIFO. A write on a full FIFO is
// accepted when a read happens in the same cycle.
module word_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_rd = i_rd && !o_empty;
    assign w_do_wr = i_wr && (!o_full || w_do_rd);
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    // Pointer bookkeeping; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_wr) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            if (w_do_rd) r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage array, written only on an accepted write.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/jpeg_byte_stuffer.sv
// JPEG entropy-stream byte stuffer: buffers packed words, serializes them
// byte by byte, inserts 8'h00 after each 8'hFF and appends the EOI marker.
// Handshake: a byte moves on a rising edge where ovalid and oready are both
// high; once ovalid is raised, ovalid/odata hold until that transfer.
module jpeg_byte_stuffer
    import jpeg_byte_stuffer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ivalid,
    input  logic [31:0] idata,
    input  logic [2:0]  ibytes,
    input  logic        iflush,
    output logic        ovalid,
    output logic [7:0]  odata,
    input  logic        oready,
    output logic        odone,
    output logic        overflow,
    output logic [2:0]  dbg_state
);
    // Input side
    logic               w_bytes_ok;
    logic               w_word_in;
    logic               w_enq;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_head_last;
    logic [2:0]         w_head_bytes;
    logic [31:0]        w_head_data;

    // Serializer
    state_t      r_state;
    logic [31:0] r_word;
    logic [2:0]  r_bytes;
    logic        r_last;
    logic [2:0]  r_idx;
    logic        r_d9_sent;
    logic        r_ovalid;
    logic [7:0]  r_odata;
    logic        r_odone;
    logic        r_overflow;

    logic        w_free;
    logic [7:0]  w_cur_byte;
    logic [2:0]  w_idx_nx;
    logic        w_word_end;
    logic        w_load;
    state_t      w_load_state;
    state_t      w_after_word;

    assign w_bytes_ok = (ibytes != 3'd0) && (ibytes <= 3'd4);
    assign w_word_in  = ivalid && w_bytes_ok;
    assign w_enq      = w_word_in || iflush;
    assign w_entry    = w_word_in ? {iflush, ibytes, idata} : {1'b1, 3'd0, 32'd0};

    assign w_head_last  = w_head[35];
    assign w_head_bytes = w_head[34:32];
    assign w_head_data  = w_head[31:0];

    word_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_enq),
        .i_wdata (w_entry),
        .i_rd    (w_load),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Decide whether the current word finishes this cycle and whether the
    // next FIFO head is pulled in, so consecutive words leave without a gap.
    always_comb begin
        w_free     = !r_ovalid || oready;
        w_cur_byte = byte_sel(r_word, r_idx[1:0]);
        w_idx_nx   = r_idx + 3'd1;
        w_word_end = 1'b0;
        if (w_free) begin
            if (r_state == ST_EMIT && w_cur_byte != EOI_HI && w_idx_nx == r_bytes) w_word_end = 1'b1;
            if (r_state == ST_STUFF && r_idx == r_bytes) w_word_end = 1'b1;
        end
        w_load       = !w_empty && ((r_state == ST_LOAD) || (w_word_end && !r_last));
        w_load_state = (w_head_bytes == 3'd0) ? ST_EOI_FF : ST_EMIT;
        if (r_last)      w_after_word = ST_EOI_FF;
        else if (w_load) w_after_word = w_load_state;
        else             w_after_word = ST_LOAD;
    end

    // Serializer FSM with registered byte output; the state names the next
    // byte to place into the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_LOAD;
            r_word    <= '0;
            r_bytes   <= '0;
            r_last    <= 1'b0;
            r_idx     <= '0;
            r_d9_sent <= 1'b0;
            r_ovalid  <= 1'b0;
            r_odata   <= '0;
            r_odone   <= 1'b0;
        end else begin
            r_odone <= 1'b0;
            if (r_ovalid && oready) r_ovalid <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_load) r_state <= w_load_state;
                end
                ST_EMIT: begin
                    if (w_free) begin
                        r_ovalid <= 1'b1;
                        r_odata  <= w_cur_byte;
                        r_idx    <= w_idx_nx;
                        if (w_cur_byte == EOI_HI)    r_state <= ST_STUFF;
                        else if (w_idx_nx == r_bytes) r_state <= w_after_word;
                    end
                end
                ST_STUFF: begin
                    if (w_free) begin
                        r_ovalid <= 1'b1;
                        r_odata  <= STUFF;
                        r_state  <= (r_idx == r_bytes) ? w_after_word : ST_EMIT;
                    end
                end
                ST_EOI_FF: begin
                    if (w_free) begin
                        r_ovalid  <= 1'b1;
                        r_odata   <= EOI_HI;
                        r_d9_sent <= 1'b0;
                        r_state   <= ST_EOI_D9;
                    end
                end
                ST_EOI_D9: begin
                    if (!r_d9_sent) begin
                        if (w_free) begin
                            r_ovalid  <= 1'b1;
                            r_odata   <= EOI_LO;
                            r_d9_sent <= 1'b1;
                        end
                    end else if (oready) begin
                        r_odone <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_LOAD;
                end
                default: r_state <= ST_LOAD;
            endcase
            if (w_load) begin
                r_word  <= w_head_data;
                r_bytes <= w_head_bytes;
                r_last  <= w_head_last;
                r_idx   <= 3'd0;
            end
        end
    end

    // Sticky drop flag: an enqueue on a full FIFO with no same-cycle dequeue.
    always_ff @(posedge clk) begin
        if (rst) r_overflow <= 1'b0;
        else if (w_enq && w_full && !w_load) r_overflow <= 1'b1;
    end

    assign ovalid    = r_ovalid;
    assign odata     = r_odata;
    assign odone     = r_odone;
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

endmodule
